// File: rtl/controlador_cifra.sv
// controlador_cifra: sequencer for one Simon 128/128 block encryption.
// Loads key and plaintext on accept, runs key schedule and round function
// in lockstep for RODADAS cycles, then holds the ciphertext until taken.
module controlador_cifra #(
  parameter int unsigned RODADAS = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] chave_i,
  input  logic [127:0] texto_i,
  input  logic         valido_i,
  output logic         pronto_o,
  output logic [127:0] cifra_o,
  output logic         valido_o,
  input  logic         pronto_i,
  output logic         ocupado_o,
  output logic [6:0]   rodada_o
);

  localparam int unsigned W    = 64;
  localparam int unsigned CW   = 7;
  localparam int unsigned ZW   = 6;
  localparam int unsigned ZLEN = 62;

  localparam logic [W-1:0]  C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [61:0]   Z_SEQ   = 62'b11001101101001111110001000010100011001001011000000111011110101;
  localparam logic [CW-1:0] ULTIMA  = CW'(RODADAS - 1);
  localparam logic [ZW-1:0] Z_MAX   = ZW'(ZLEN - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    RODADA = 2'd1,
    SAIDA  = 2'd2
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;
  logic            w_aceita;
  logic [W-1:0]    r_x, r_y, r_ka, r_kb;
  logic [CW-1:0]   r_cont;
  logic [ZW-1:0]   r_idx;
  logic [127:0]    r_cifra;
  logic            r_pronto, r_valido, r_ocupado;

  logic [W-1:0]    w_f, w_x_nxt, w_kb_r3, w_kb_r4, w_kb_nxt;
  logic            w_z, w_ultima;

  // Round function and key-schedule step on the current registers
  assign w_f      = ({r_x[62:0], r_x[63]} & {r_x[55:0], r_x[63:56]}) ^ {r_x[61:0], r_x[63:62]};
  assign w_x_nxt  = r_y ^ w_f ^ r_ka;
  assign w_kb_r3  = {r_kb[2:0], r_kb[63:3]};
  assign w_kb_r4  = {r_kb[3:0], r_kb[63:4]};
  assign w_z      = Z_SEQ[r_idx];
  assign w_kb_nxt = r_ka ^ w_kb_r3 ^ w_kb_r4 ^ C_CONST ^ {{(W-1){1'b0}}, w_z};
  assign w_ultima = (r_cont == ULTIMA);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  // Next-state logic; a request is only taken while idle
  always_comb begin
    w_prox   = r_estado;
    w_aceita = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (valido_i) begin
          w_aceita = 1'b1;
          w_prox   = RODADA;
        end
      end
      RODADA: begin
        if (w_ultima) w_prox = SAIDA;
      end
      SAIDA: begin
        if (pronto_i) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // Datapath: load on accept, one Simon round per cycle while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_ka    <= '0;
      r_kb    <= '0;
      r_cont  <= '0;
      r_idx   <= '0;
      r_cifra <= '0;
    end else if (w_aceita) begin
      r_x    <= texto_i[127:64];
      r_y    <= texto_i[63:0];
      r_ka   <= chave_i[63:0];
      r_kb   <= chave_i[127:64];
      r_cont <= '0;
      r_idx  <= '0;
    end else if (r_estado == RODADA) begin
      r_x    <= w_x_nxt;
      r_y    <= r_x;
      r_ka   <= r_kb;
      r_kb   <= w_kb_nxt;
      r_cont <= w_ultima ? '0 : r_cont + CW'(1);
      r_idx  <= (r_idx == Z_MAX) ? '0 : r_idx + ZW'(1);
      if (w_ultima) r_cifra <= {w_x_nxt, r_x};
    end
  end

  // Handshake/status flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pronto  <= 1'b1;
      r_valido  <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_pronto  <= (w_prox == OCIOSO);
      r_valido  <= (w_prox == SAIDA);
      r_ocupado <= (w_prox != OCIOSO);
    end
  end

  assign pronto_o  = r_pronto;
  assign valido_o  = r_valido;
  assign ocupado_o = r_ocupado;
  assign cifra_o   = r_cifra;
  assign rodada_o  = r_cont;

endmodule

// File: tb/tb_controlador_cifra.sv
// Bench for controlador_cifra: four instances (68, 1, 62, 63 rounds)
// checked against a behavioural Simon 128/128 model.
module tb_controlador_cifra;

  localparam int ND = 4;

  localparam logic [127:0] STD_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] STD_PT  = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] STD_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] t_chave   [ND];
  logic [127:0] t_texto   [ND];
  logic         t_valido_i[ND];
  logic         t_pronto_i[ND];
  logic         t_pronto_o[ND];
  logic [127:0] t_cifra   [ND];
  logic         t_valido_o[ND];
  logic         t_ocupado [ND];
  logic [6:0]   t_rodada  [ND];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    controlador_cifra #(
      .RODADAS((g == 0) ? 68 : (g == 1) ? 1 : (g == 2) ? 62 : 63)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .chave_i  (t_chave[g]),
      .texto_i  (t_texto[g]),
      .valido_i (t_valido_i[g]),
      .pronto_o (t_pronto_o[g]),
      .cifra_o  (t_cifra[g]),
      .valido_o (t_valido_o[g]),
      .pronto_i (t_pronto_i[g]),
      .ocupado_o(t_ocupado[g]),
      .rodada_o (t_rodada[g])
    );
  end

  function automatic int rnd_of(input int g);
    return (g == 0) ? 68 : (g == 1) ? 1 : (g == 2) ? 62 : 63;
  endfunction

  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  // Reference Simon 128/128: expand all round keys, then run the rounds
  function automatic logic [127:0] simon_ref(input logic [127:0] key,
                                             input logic [127:0] pt, input int n);
    logic [63:0] rk [0:129];
    logic [63:0] x, y, t;
    logic [61:0] z2;
    z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    rk[0] = key[63:0];
    rk[1] = key[127:64];
    for (int i = 0; i < n; i++) begin
      t = rol64(rk[i+1], 61);
      t = t ^ rol64(t, 63);
      rk[i+2] = ~rk[i] ^ t ^ {63'b0, z2[61 - (i % 62)]} ^ 64'd3;
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < n; i++) begin
      t = x;
      x = y ^ (rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    check({tag, "_pronto"},  128'(t_pronto_o[d]), 128'(1));
    check({tag, "_valido"},  128'(t_valido_o[d]), 128'(0));
    check({tag, "_ocupado"}, 128'(t_ocupado[d]),  128'(0));
    check({tag, "_rodada"},  128'(t_rodada[d]),   128'(0));
    check({tag, "_cifra"},   t_cifra[d],          128'(0));
  endtask

  // Wait for pronto_o, present a request, return the accept cycle
  task automatic do_accept(input int d, input logic [127:0] k, input logic [127:0] p,
                           input logic keep_valid, output int t_acc);
    int w;
    w = 0;
    @(negedge clk);
    while (t_pronto_o[d] !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("pronto_before_accept", 128'(t_pronto_o[d]), 128'(1));
    t_chave[d]    = k;
    t_texto[d]    = p;
    t_valido_i[d] = 1'b1;
    @(posedge clk);
    #1;
    t_acc = cyc;
    if (!keep_valid) t_valido_i[d] = 1'b0;
  endtask

  // Follow the block to completion, optionally scrambling inputs and back-pressuring
  task automatic wait_result(input int d, input logic [127:0] exp, input int bp,
                             input logic scramble, input string name);
    int           cnt;
    logic         seq_ok, stab_ok;
    logic [127:0] held;
    cnt    = 0;
    seq_ok = 1'b1;
    while (cnt < 400) begin
      @(negedge clk);
      if (t_valido_o[d] === 1'b1) break;
      if (t_pronto_o[d] !== 1'b0 || t_ocupado[d] !== 1'b1 || t_rodada[d] !== 7'(cnt))
        seq_ok = 1'b0;
      if (scramble) begin
        t_texto[d] = rand128();
        t_chave[d] = rand128();
      end
      @(posedge clk);
      cnt++;
    end
    check({name, "_latency"}, 128'(cnt), 128'(rnd_of(d)));
    check({name, "_round_seq"}, 128'(seq_ok), 128'(1));
    check({name, "_cifra"}, t_cifra[d], exp);
    check({name, "_busy_out"}, 128'({t_ocupado[d], t_pronto_o[d]}), 128'(2'b10));
    held = t_cifra[d];
    if (bp > 0) begin
      stab_ok = 1'b1;
      for (int i = 0; i < bp; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (t_valido_o[d] !== 1'b1 || t_cifra[d] !== held || t_pronto_o[d] !== 1'b0)
          stab_ok = 1'b0;
      end
      check({name, "_backpressure_stable"}, 128'(stab_ok), 128'(1));
    end
    t_pronto_i[d] = 1'b1;
    @(posedge clk);
    #1;
    t_pronto_i[d] = 1'b0;
    t_valido_i[d] = 1'b0;
    check({name, "_after_xfer"},
          128'({t_valido_o[d], t_pronto_o[d], t_ocupado[d]}), 128'(3'b010));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
    int           bp;
    logic         busy;
  } vec_t;

  vec_t tab [8];

  initial begin
    int   t_acc, t_prev, w;
    logic [127:0] k, p;
    logic quiet;

    for (int d = 0; d < ND; d++) begin
      t_chave[d] = '0; t_texto[d] = '0; t_valido_i[d] = 1'b0; t_pronto_i[d] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) check_reset(d, $sformatf("reset%0d", d));
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: standard, zero key back-to-back, back-pressure, busy, random
    tab[0] = '{STD_KEY, STD_PT, STD_CT, 0, 1'b0};
    tab[1] = '{128'(0), 128'(0), simon_ref(128'(0), 128'(0), 68), 0, 1'b0};
    tab[2] = '{STD_KEY, STD_PT, STD_CT, 10, 1'b0};
    tab[3] = '{STD_KEY, STD_PT, STD_CT, 0, 1'b1};
    for (int i = 4; i < 8; i++) begin
      k = rand128();
      p = rand128();
      tab[i] = '{k, p, simon_ref(k, p, 68), (i == 5) ? 3 : 0, 1'b0};
    end

    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      do_accept(0, tab[i].key, tab[i].pt, tab[i].busy, t_acc);
      if (i > 0)
        check($sformatf("tab%0d_throughput", i), 128'(t_acc - t_prev), 128'(70 + tab[i-1].bp));
      t_prev = t_acc;
      wait_result(0, tab[i].exp, tab[i].bp, tab[i].busy, $sformatf("tab%0d", i));
    end

    // Reduced round counts, including the z index wrap at round 62
    for (int d = 1; d < ND; d++) begin
      for (int r = 0; r < 3; r++) begin
        k = (r == 0) ? STD_KEY : rand128();
        p = (r == 0) ? STD_PT  : rand128();
        do_accept(d, k, p, 1'b0, t_acc);
        wait_result(d, simon_ref(k, p, rnd_of(d)), 0, 1'b0, $sformatf("r%0d_v%0d", rnd_of(d), r));
      end
    end

    // Reset in the middle of a block, then re-issue the standard vector
    do_accept(0, STD_KEY, STD_PT, 1'b0, t_acc);
    w = 0;
    @(negedge clk);
    while (t_rodada[0] !== 7'd30 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("midreset_reached_round30", 128'(t_rodada[0]), 128'(30));
    rst_n = 1'b0;
    #1;
    check_reset(0, "midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (t_valido_o[0] !== 1'b0 || t_pronto_o[0] !== 1'b1) quiet = 1'b0;
    end
    check("midreset_no_stale_output", 128'(quiet), 128'(1));
    do_accept(0, STD_KEY, STD_PT, 1'b0, t_acc);
    wait_result(0, STD_CT, 0, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_cifra.md
# controlador_cifra

Sequencer for one Simon 128/128 block encryption: accepts a 128-bit key and a 128-bit plaintext via valid/ready, runs the key schedule and the round function in lockstep for RODADAS cycles, then holds the ciphertext until the consumer takes it. It sits between the host-side request interface and the Simon round datapath. It reuses the existing key-schedule equations, but adds a per-block key load, so no reset is needed between keys.

## Interface
- RODADAS, 68: number of rounds per block (legal 1..127; 68 is the Simon 128/128 value).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- chave_i  in  128  key; chave_i[63:0] is round key k0, chave_i[127:64] is k1.
- texto_i  in  128  plaintext {x, y}; x = texto_i[127:64].
- valido_i  in  1  request valid.
- pronto_o  out  1  controller can accept a request (high only in OCIOSO).
- cifra_o  out  128  ciphertext {x, y}, held stable while valido_o = 1.
- valido_o  out  1  ciphertext valid.
- pronto_i  in  1  consumer ready.
- ocupado_o  out  1  high in RODADA or SAIDA.
- rodada_o  out  7  current round index (0..RODADAS-1) while in RODADA, else 0.

## Operation
- FSM states: OCIOSO, RODADA, SAIDA. Reset state is OCIOSO.
- OCIOSO:
  - pronto_o = 1.
  - On valido_i & pronto_o: load x, y from texto_i; load kA = chave_i[63:0] and kB = chave_i[127:64]; clear round counter and z index; go to RODADA.
- RODADA, each edge:
  - f(x) = (ROL1 x & ROL8 x) ^ ROL2 x.
  - x <= y ^ f(x) ^ kA; y <= x.
  - kA <= kB.
  - kB <= kA ^ ROR3 kB ^ ROR1(ROR3 kB) ^ c ^ z[idx], with c = 64'hFFFF_FFFF_FFFF_FFFC.
  - Counter increments.
  - When the counter = RODADAS-1, go to SAIDA after this round.
- z sequence:
  - Bit j of 62'b11001101101001111110001000010100011001001011000000111011110101, LSB first.
  - idx is a 6-bit index that wraps 61 -> 0, so round i uses z[i mod 62].
- SAIDA:
  - valido_o = 1; cifra_o = {x, y}.
  - On pronto_i: go to OCIOSO.
  - No new request is accepted in the same cycle; pronto_o rises the following cycle.
- Input sampling:
  - chave_i and texto_i are sampled only on the accept edge.
  - Later changes have no effect on a block in progress.
- valido_i while busy is ignored: not queued, not dropped silently into state. The requester holds it until pronto_o.
- All arithmetic is 64-bit, rotations modulo 64, no carries.

## Timing
- Reset values:
  - State OCIOSO; pronto_o = 1; valido_o = 0; ocupado_o = 0.
  - cifra_o = 0; rodada_o = 0; x, y, kA, kB, counter and idx all 0.
- Reset mid-operation aborts immediately (asynchronous). No partial result is ever presented.
- Latency:
  - Accept at edge T0; rounds execute on edges T1..T(RODADAS).
  - valido_o is high after edge T(RODADAS): 68 cycles after accept for the default.
- Throughput, with pronto_i held high: one block per RODADAS+2 cycles (accept, RODADAS rounds, one SAIDA cycle, then OCIOSO).
- Output stability:
  - cifra_o and valido_o are registered/state-derived, with no combinational path from pronto_i.
  - Both remain stable for as long as pronto_i = 0.
- ocupado_o and rodada_o are registered/state-decoded and glitch-free.

## Test plan
- Standard vector:
  - Stimulus: chave_i = 128'h0f0e0d0c0b0a0908_0706050403020100, texto_i = 128'h6373656420737265_6c6c657661727420, pronto_i = 1.
  - Required: cifra_o = 128'h49681b1e1e54fe3f_65aa832af84e0bbc, valido_o exactly 68 cycles after the accept edge.
- Back-pressure:
  - Stimulus: same vector with pronto_i = 0 for 10 cycles after valido_o.
  - Required: cifra_o and valido_o stable; pronto_o = 0 throughout; transfer on the first pronto_i = 1; pronto_o = 1 on the next cycle.
- Busy request and input change:
  - Stimulus: valido_i held high with texto_i changed during RODADA.
  - Required: no second accept before OCIOSO; the first ciphertext matches the originally sampled texto_i.
- Back-to-back blocks with different keys:
  - Stimulus: vector 1, then key 0, plaintext 0.
  - Required: result 2 matches the software model; no state leaks from block 1 (z index and key restart).
- Reset mid-block:
  - Stimulus: rst_n low at round 30, then the standard vector re-issued.
  - Required: outputs take reset values at once; no valido_o from the aborted block; the new result is correct.
- Reduced rounds:
  - Stimulus: RODADAS = 1, 62, 63, against a software model.
  - Required: matching ciphertext; idx wrap verified at round 62.
